// File: rtl/cache_2way_ctrl.sv
// cache_2way_ctrl: two-way set-associative, write-back, write-allocate cache
// controller with internal tag/data storage, per-set LRU and a pipelined
// memory port (reads return in issue order, any latency).
// Optional build macro CACHE_2WAY_STATS_EN adds saturating hit/miss counters.
module cache_2way_ctrl #(
    parameter int INDEX_BITS     = 6,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        cache_hit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_stall,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid
`ifdef CACHE_2WAY_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam int WB       = $clog2(WORDS_PER_LINE);
    localparam int TAG_BITS = 15 - INDEX_BITS - WB;
    localparam int SETS     = 1 << INDEX_BITS;
    localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_FINISH, S_ERR} state_t;
    state_t state_q, state_d;

    // Line state and storage
    logic [SETS-1:0]     valid_q [2];
    logic [SETS-1:0]     dirty_q [2];
    logic [SETS-1:0]     lru_q;          // way to evict next
    logic [TAG_BITS-1:0] tag_q   [2][SETS];
    logic [15:0]         data_q  [2][SETS][WORDS_PER_LINE];

    // Latched request (byte bit is never needed once the request is accepted)
    logic [15:1] req_addr_q;
    logic [15:0] req_data_q;
    logic        req_wr_q;

    logic        victim_q;
    logic [WB:0] cnt_q;     // memory requests accepted in WB/FILL
    logic [WB-1:0] ret_q;   // read beats installed in FILL

    logic [WB-1:0]         req_word;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    assign req_word = req_addr_q[WB:1];
    assign req_idx  = req_addr_q[WB+INDEX_BITS:WB+1];
    assign req_tag  = req_addr_q[15:WB+INDEX_BITS+1];

    logic hit0, hit1, lookup_hit, victim_way, acc_way, access, last_beat;
    logic req_bad, req_ok;
    assign hit0       = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1       = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign lookup_hit = hit0 || hit1;
    // Empty ways are filled before anything is evicted, way 0 first.
    assign victim_way = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
    assign acc_way    = (state_q == S_FINISH) ? victim_q : hit1;
    assign access     = ((state_q == S_LOOKUP) && lookup_hit) || (state_q == S_FINISH);
    assign last_beat  = (state_q == S_FILL) && mem_rvalid && (ret_q == LAST_WORD);
    assign req_bad    = (rd && wr) || ((rd || wr) && addr[0]);
    assign req_ok     = (rd || wr) && !req_bad;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        cache_hit = 1'b0;
        stall     = 1'b1;
        err       = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        data_out  = '0;
        case (state_q)
            S_IDLE: begin
                stall = 1'b0;
                if (req_bad)     state_d = S_ERR;
                else if (req_ok) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    done      = 1'b1;
                    cache_hit = 1'b1;
                    stall     = 1'b0;
                    state_d   = S_IDLE;
                end else if (valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx]) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_WB: begin
                mem_wr    = 1'b1;
                mem_addr  = {tag_q[victim_q][req_idx], req_idx, cnt_q[WB-1:0], 1'b0};
                mem_wdata = data_q[victim_q][req_idx][cnt_q[WB-1:0]];
                if (!mem_stall && (cnt_q[WB-1:0] == LAST_WORD)) state_d = S_FILL;
            end
            S_FILL: begin
                mem_rd = !cnt_q[WB];
                if (mem_rd) mem_addr = {req_tag, req_idx, cnt_q[WB-1:0], 1'b0};
                if (last_beat) state_d = S_FINISH;
            end
            S_FINISH: begin
                done    = 1'b1;
                stall   = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: err = 1'b1;
            default: state_d = S_IDLE;
        endcase
        if (done && !req_wr_q) data_out = data_q[acc_way][req_idx][req_word];
    end

    // Control state: counters, victim choice, valid/dirty/LRU bits
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            ret_q      <= '0;
            victim_q   <= 1'b0;
            lru_q      <= '0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
        end else begin
            case (state_q)
                S_LOOKUP: begin
                    victim_q <= victim_way;
                    cnt_q    <= '0;
                    ret_q    <= '0;
                end
                S_WB: begin
                    if (!mem_stall) cnt_q <= (cnt_q[WB-1:0] == LAST_WORD) ? '0 : cnt_q + 1'b1;
                end
                S_FILL: begin
                    if (mem_rd && !mem_stall) cnt_q <= cnt_q + 1'b1;
                    if (mem_rvalid) ret_q <= ret_q + 1'b1;
                    if (last_beat) begin
                        valid_q[victim_q][req_idx] <= 1'b1;
                        dirty_q[victim_q][req_idx] <= 1'b0;
                    end
                end
                default: begin
                    cnt_q <= '0;
                    ret_q <= '0;
                end
            endcase
            if (access) begin
                lru_q[req_idx] <= ~acc_way;
                if (req_wr_q) dirty_q[acc_way][req_idx] <= 1'b1;
            end
        end
    end

    // Datapath: request latch, line install, tag update, write merge
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE) begin
            req_addr_q <= addr[15:1];
            req_data_q <= data_in;
            req_wr_q   <= wr;
        end
        if ((state_q == S_FILL) && mem_rvalid) data_q[victim_q][req_idx][ret_q] <= mem_rdata;
        if (last_beat) tag_q[victim_q][req_idx] <= req_tag;
        if (access && req_wr_q) data_q[acc_way][req_idx][req_word] <= req_data_q;
    end

`ifdef CACHE_2WAY_STATS_EN
    // Saturating hit/miss counters, one count per completed request
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (done) begin
            if (cache_hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: doc/cache_2way_ctrl.md
# cache_2way_ctrl

Parametrised two-way set-associative, write-back, write-allocate cache controller with internal tag/data storage and an external pipelined memory port. It succeeds the direct-mapped single-configuration memory system: same processor-side handshake (rd/wr in, done/stall/cache_hit/err out), but with configurable geometry and memory latency tolerance, and per-set LRU replacement. It sits between the processor pipeline (fetch or memory stage) and the main memory model.

## Interface
- INDEX_BITS, 6: set index width; 2^INDEX_BITS sets.
- WORDS_PER_LINE, 4: 16-bit words per line, power of two in 2..8; WB = log2(WORDS_PER_LINE).
- TAG_BITS, derived = 15 - INDEX_BITS - WB.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high.
- addr  in  16  byte address. Bit 0 = byte, [WB:1] = word, next INDEX_BITS = index, rest = tag.
- data_in  in  16  write data.
- rd, wr  in  1  request strobes, sampled only in IDLE.
- data_out  out  16  read data, valid when done=1 for a read.
- done  out  1  one-cycle completion pulse.
- stall  out  1  controller busy; new requests ignored.
- cache_hit  out  1  with done: request hit without memory traffic.
- err  out  1  sticky error.
- mem_addr  out  16  memory word address (bit 0 = 0).
- mem_wdata  out  16  memory write data.
- mem_rd, mem_wr  out  1  request; accepted in a cycle with mem_stall=0.
- mem_stall  in  1  memory cannot accept this cycle.
- mem_rdata  in  16  read return data.
- mem_rvalid  in  1  read return valid; returns arrive in issue order.

## Operation
- Storage: per way per set: valid, dirty, tag, WORDS_PER_LINE data words; per set one LRU bit (way to evict next).
- IDLE: rd&wr both high, or (rd|wr) with addr[0]=1 -> ERR. Else rd|wr latches addr, data_in, op -> LOOKUP.
- LOOKUP: compare tag in both ways. Hit: read returns word / write merges word and sets dirty; LRU := other way; done=1, cache_hit=1 -> IDLE. Miss: victim = first invalid way (way0 preferred), else LRU way; victim valid&dirty -> WB, else FILL.
- WB: issue WORDS_PER_LINE writes, word 0 first, addr {victim tag, index, word, 1'b0}, one per accepted cycle; after last acceptance -> FILL.
- FILL: issue WORDS_PER_LINE reads of {req tag, index, word, 1'b0}, word 0 first, back to back while mem_stall=0; independently install each mem_rvalid beat into next word of victim; after last beat: valid=1, dirty=0, tag written -> FINISH.
- FINISH: perform the access on the new line as a hit (write sets dirty), LRU := other way; done=1, cache_hit=0 -> IDLE.
- ERR: err=1, stall=1, stays until rst.
- stall=1 in every state except IDLE and the done cycle.

## Timing
- Reset: all valid, dirty, LRU bits cleared; state IDLE; issue/return counters 0; every output 0 the cycle after rst sampled high.
- Hit latency: request in cycle N, done in N+1.
- Clean miss, memory accepting every cycle, read latency L: done at N+1+WORDS_PER_LINE+L+1 at minimum.
- mem_stall=1: mem_rd/mem_wr and mem_addr/mem_wdata held unchanged; no request counted; no duplicate issue.
- Stall and rvalid in same cycle: install still happens.
- Reset mid-operation: aborts; mem_rd/mem_wr low next cycle; mem_rvalid beats arriving in IDLE ignored; partially filled line stays invalid.
- rd/wr held high across done: re-sampled in IDLE as a new request next cycle.

## Configuration
- CACHE_2WAY_STATS_EN defined: outputs hit_count[15:0], miss_count[15:0] added; increment on each done with cache_hit=1 / 0; saturate at 16'hFFFF; cleared by rst.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Cold read 0x0040 (mem preloaded word=addr) -> mem_rd at 0x0040,0x0042,0x0044,0x0046; done with data_out=0x0040, cache_hit=0; repeat read -> done next cycle, cache_hit=1.
- Read 0x0040, write 0x0040=0xBEEF (hit), read 0x0240 (same set 8, way1), read 0x0440 -> four mem_wr to 0x0040..0x0046 with 0xBEEF first, then fill of 0x0440; read 0x0240 -> hit.
- Assert mem_stall for 5 cycles at second fill read -> mem_addr held 0x0042, exactly 4 reads issued, correct data.
- rd=wr=1 in IDLE -> err=1, stall=1 sticky until rst; after rst err=0.
- Reset during WB -> outputs 0 next cycle; read 0x0040 then misses (cache_hit=0).
- With CACHE_2WAY_STATS_EN: 1 miss + 3 hits -> hit_count=3, miss_count=1.
